// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
//   Decodes RV32I OP / OP-IMM instructions, and BRANCH instructions when
//   enabled, into an ALU op code, an immediate and an operand-select flag.
//   The result is held in a single output register with a valid/ready
//   handshake. The latency is 1 cycle and the block accepts one instruction
//   per cycle.
//
// Configuration macro:
//   ALU_DEC_BRANCH_EN - when defined, BRANCH (1100011) is decoded to compare
//                       ops. When it is undefined, BRANCH is treated as illegal.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   instr_i        32-bit instruction word
//   instr_valid_i  instr_i valid
//   instr_ready_o  decoder can accept instr_i this cycle
//   out_valid_o    registered decode result valid
//   out_ready_i    consumer takes the result this cycle
//   alu_op_o       5-bit ALU op code
//   imm_o          decoded immediate
//   use_imm_o      second operand is imm_o instead of rs2
//   illegal_o      instruction not decodable here
//   illegal_cnt_o  saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module alu_op_decoder (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [4:0]  alu_op_o,
    output logic [31:0] imm_o,
    output logic        use_imm_o,
    output logic        illegal_o,
    output logic [7:0]  illegal_cnt_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_op;
    logic [31:0] w_imm;
    logic        w_use_imm;
    logic        w_ill;
    logic        w_accept;
    logic        w_unused;

    logic        r_valid;
    logic [4:0]  r_op;
    logic [31:0] r_imm;
    logic        r_use_imm;
    logic        r_ill;
    logic [7:0]  r_ill_cnt;

    assign w_opcode = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];
    // The register fields are not needed for the ALU op.
    assign w_unused = ^{instr_i[19:15], instr_i[11:7]};

    // Ready is gated by reset so that nothing is accepted while rst_ni is low.
    // During reset r_valid is already 0.
    assign instr_ready_o = rst_ni && (!r_valid || out_ready_i);
    assign w_accept      = instr_valid_i && instr_ready_o;

    // Combinational decode. Every path starts from the illegal defaults and
    // overrides them only on an encoding it recognises.
    always_comb begin
        w_op      = 5'b00000;
        w_imm     = 32'h0;
        w_use_imm = 1'b0;
        w_ill     = 1'b1;
        if (instr_i[1:0] == 2'b11) begin
            case (w_opcode)
                OPC_OP: begin
                    if (w_f7 == F7_ZERO) begin
                        w_op  = {2'b00, w_f3};
                        w_ill = 1'b0;
                    end else if (w_f7 == F7_ALT) begin
                        if (w_f3 == 3'b000) begin
                            w_op  = 5'b10000;   // SUB
                            w_ill = 1'b0;
                        end else if (w_f3 == 3'b101) begin
                            w_op  = 5'b01101;   // SRA
                            w_ill = 1'b0;
                        end
                    end
                end
                OPC_OP_IMM: begin
                    case (w_f3)
                        3'b001: begin
                            if (w_f7 == F7_ZERO) begin
                                w_op      = 5'b00001;
                                w_imm     = {27'h0, instr_i[24:20]};
                                w_use_imm = 1'b1;
                                w_ill     = 1'b0;
                            end
                        end
                        3'b101: begin
                            if (w_f7 == F7_ZERO || w_f7 == F7_ALT) begin
                                // funct7 bit 5 selects SRA (01101) over SRL (00101).
                                w_op      = {1'b0, w_f7[5], 3'b101};
                                w_imm     = {27'h0, instr_i[24:20]};
                                w_use_imm = 1'b1;
                                w_ill     = 1'b0;
                            end
                        end
                        default: begin
                            // The funct3 value is the op code for the non-shift immediates.
                            w_op      = {2'b00, w_f3};
                            w_imm     = {{20{instr_i[31]}}, instr_i[31:20]};
                            w_use_imm = 1'b1;
                            w_ill     = 1'b0;
                        end
                    endcase
                end
`ifdef ALU_DEC_BRANCH_EN
                OPC_BRANCH: begin
                    if (w_f3 != 3'b010 && w_f3 != 3'b011) begin
                        w_op  = {2'b11, w_f3};
                        w_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                 instr_i[30:25], instr_i[11:8], 1'b0};
                        w_ill = 1'b0;
                    end
                end
`else
                // BRANCH decode is not built. The opcode falls through to illegal.
                OPC_BRANCH: ;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= 1'b0;
            r_op      <= 5'b0;
            r_imm     <= 32'h0;
            r_use_imm <= 1'b0;
            r_ill     <= 1'b0;
            r_ill_cnt <= 8'h0;
        end else begin
            if (w_accept) begin
                r_valid   <= 1'b1;
                r_op      <= w_op;
                r_imm     <= w_imm;
                r_use_imm <= w_use_imm;
                r_ill     <= w_ill;
                if (w_ill && r_ill_cnt != 8'hFF)
                    r_ill_cnt <= r_ill_cnt + 8'd1;
            end else if (out_ready_i) begin
                // Drain: the valid bit drops and the data outputs keep their last value.
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o   = r_valid;
    assign alu_op_o      = r_op;
    assign imm_o         = r_imm;
    assign use_imm_o     = r_use_imm;
    assign illegal_o     = r_ill;
    assign illegal_cnt_o = r_ill_cnt;

endmodule

// File: tb/tb_alu_op_decoder.sv
module tb_alu_op_decoder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [4:0]  alu_op_o;
    logic [31:0] imm_o;
    logic        use_imm_o;
    logic        illegal_o;
    logic [7:0]  illegal_cnt_o;

    int errs = 0;
    int chks = 0;
    int exp_cnt = 0;

    alu_op_decoder dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .alu_op_o      (alu_op_o),
        .imm_o         (imm_o),
        .use_imm_o     (use_imm_o),
        .illegal_o     (illegal_o),
        .illegal_cnt_o (illegal_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one instruction with out_ready_i=1 and sample the registered result just after the edge.
    task automatic issue(input logic [31:0] ins);
        @(negedge clk_i);
        instr_i       = ins;
        instr_valid_i = 1'b1;
        out_ready_i   = 1'b1;
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b0;
    endtask

    // Directed vectors: instr, op, imm, use_imm, illegal
    typedef struct {
        logic [31:0] ins;
        logic [4:0]  op;
        logic [31:0] imm;
        logic        use_imm;
        logic        ill;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst_ni        = 1'b0;
        instr_i       = 32'h0;
        instr_valid_i = 1'b0;
        out_ready_i   = 1'b0;

        vecs.push_back('{32'h40B50533, 5'b10000, 32'h0,        1'b0, 1'b0, "sub"});
        vecs.push_back('{32'hFFF00093, 5'b00000, 32'hFFFFFFFF, 1'b1, 1'b0, "addi_m1"});
        vecs.push_back('{32'h4032D293, 5'b01101, 32'h00000003, 1'b1, 1'b0, "srai3"});
`ifdef ALU_DEC_BRANCH_EN
        vecs.push_back('{32'h00208463, 5'b11000, 32'h00000008, 1'b0, 1'b0, "beq8"});
`else
        vecs.push_back('{32'h00208463, 5'b00000, 32'h0,        1'b0, 1'b1, "beq8"});
`endif
        vecs.push_back('{32'h003100B3, 5'b00000, 32'h0,        1'b0, 1'b0, "add"});
        vecs.push_back('{32'h8000C093, 5'b00100, 32'hFFFFF800, 1'b1, 1'b0, "xori_min"});
        vecs.push_back('{32'h00209093, 5'b00001, 32'h00000002, 1'b1, 1'b0, "slli2"});
        vecs.push_back('{32'h40209093, 5'b00000, 32'h0,        1'b0, 1'b1, "slli_badf7"});
        vecs.push_back('{32'h023100B3, 5'b00000, 32'h0,        1'b0, 1'b1, "mul"});
        vecs.push_back('{32'h003100B0, 5'b00000, 32'h0,        1'b0, 1'b1, "low_bits"});
        vecs.push_back('{32'h4031D0B3, 5'b01101, 32'h0,        1'b0, 1'b0, "sra"});

        // Reset state
        #2;
        chk("rst_valid", {31'h0, out_valid_o}, 32'h0);
        chk("rst_op",    {27'h0, alu_op_o},    32'h0);
        chk("rst_imm",   imm_o,                32'h0);
        chk("rst_use",   {31'h0, use_imm_o},   32'h0);
        chk("rst_ill",   {31'h0, illegal_o},   32'h0);
        chk("rst_cnt",   {24'h0, illegal_cnt_o}, 32'h0);
        chk("rst_ready", {31'h0, instr_ready_o}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed decode vectors
        foreach (vecs[i]) begin
            issue(vecs[i].ins);
            if (vecs[i].ill) exp_cnt++;
            chk({vecs[i].name, "_valid"}, {31'h0, out_valid_o}, 32'h1);
            chk({vecs[i].name, "_op"},    {27'h0, alu_op_o},    {27'h0, vecs[i].op});
            chk({vecs[i].name, "_imm"},   imm_o,                vecs[i].imm);
            chk({vecs[i].name, "_use"},   {31'h0, use_imm_o},   {31'h0, vecs[i].use_imm});
            chk({vecs[i].name, "_ill"},   {31'h0, illegal_o},   {31'h0, vecs[i].ill});
            chk({vecs[i].name, "_cnt"},   {24'h0, illegal_cnt_o}, exp_cnt);
        end

        // Drain: no accept, so valid drops and data holds (last was sra)
        @(negedge clk_i);
        @(posedge clk_i); #1;
        chk("drain_valid", {31'h0, out_valid_o}, 32'h0);
        chk("drain_op",    {27'h0, alu_op_o},    32'h0000000D);

        // Stall: load ADD with out_ready_i=0, then offer XOR for 3 cycles
        @(negedge clk_i);
        instr_i = 32'h003100B3; instr_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        chk("stall_load_op", {27'h0, alu_op_o}, 32'h0);
        @(negedge clk_i);
        instr_i = 32'h003140B3;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", {31'h0, instr_ready_o}, 32'h0);
            @(posedge clk_i); #1;
            chk("stall_valid", {31'h0, out_valid_o}, 32'h1);
            chk("stall_op",    {27'h0, alu_op_o},    32'h0);
            @(negedge clk_i);
        end
        out_ready_i = 1'b1;
        #1;
        chk("resume_ready", {31'h0, instr_ready_o}, 32'h1);
        @(posedge clk_i); #1;
        chk("thru_xor_valid", {31'h0, out_valid_o}, 32'h1);
        chk("thru_xor_op",    {27'h0, alu_op_o},    32'h4);
        @(negedge clk_i);
        instr_i = 32'h003160B3;
        @(posedge clk_i); #1;
        chk("thru_or_valid", {31'h0, out_valid_o}, 32'h1);
        chk("thru_or_op",    {27'h0, alu_op_o},    32'h6);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("thru_end_valid", {31'h0, out_valid_o}, 32'h0);
        chk("thru_end_op",    {27'h0, alu_op_o},    32'h6);

        // Saturation: 300 all-zero words in a row
        @(negedge clk_i);
        instr_i = 32'h0; instr_valid_i = 1'b1; out_ready_i = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk_i); #1;
            chk("zero_ill", {31'h0, illegal_o}, 32'h1);
            chk("zero_op",  {27'h0, alu_op_o},  32'h0);
        end
        chk("sat_cnt", {24'h0, illegal_cnt_o}, 32'hFF);

        // Async reset while holding a result
        @(negedge clk_i);
        instr_i = 32'hFFF00093; out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        chk("pre_rst_valid", {31'h0, out_valid_o}, 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_valid", {31'h0, out_valid_o}, 32'h0);
        chk("async_cnt",   {24'h0, illegal_cnt_o}, 32'h0);
        chk("async_imm",   imm_o, 32'h0);
        chk("async_ready", {31'h0, instr_ready_o}, 32'h0);
        // An edge during reset with valid high must not load anything
        @(posedge clk_i); #1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        instr_valid_i = 1'b0;
        #1;
        chk("post_rst_valid", {31'h0, out_valid_o}, 32'h0);
        chk("post_rst_use",   {31'h0, use_imm_o},   32'h0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_op_decoder.md
ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-003 instr_i  input  32  RV32I instruction word to decode.
REQ-004 instr_valid_i  input  1  instr_i valid this cycle.
REQ-005 instr_ready_o  output  1  decoder accepts instr_i this cycle.
REQ-006 out_valid_o  output  1  registered decode result valid.
REQ-007 out_ready_i  input  1  consumer takes result this cycle.
REQ-008 alu_op_o  output  5  ALU op code, encoding per REQ-014..REQ-017.
REQ-009 imm_o  output  32  decoded immediate, sign- or zero-extended per REQ-015/016.
REQ-010 use_imm_o  output  1  second ALU operand is imm_o, not rs2.
REQ-011 illegal_o  output  1  instruction not decodable by this block.
REQ-012 illegal_cnt_o  output  8  saturating count of accepted illegal instructions.

Function
REQ-013 Handshake: accept when instr_valid_i && instr_ready_o; instr_ready_o = !out_valid_o || out_ready_i (combinational); output register loads on accept, so latency is exactly 1 cycle with full throughput (one instruction per cycle).
REQ-014 OP (opcode 0110011): funct7 0000000: funct3 000 ADD 00000, 001 SLL 00001, 010 SLTS 00010, 011 SLTU 00011, 100 XOR 00100, 101 SRL 00101, 110 OR 00110, 111 AND 00111; funct7 0100000: funct3 000 SUB 10000, 101 SRA 01101; any other funct7/funct3 pair is illegal; use_imm_o=0, imm_o=0.
REQ-015 OP-IMM (opcode 0010011): funct3 000/010/011/100/110/111 map to ADD/SLTS/SLTU/XOR/OR/AND, imm_o = sign-extended instr_i[31:20]; funct3 001 requires instr_i[31:25]=0000000 -> SLL; funct3 101 with 0000000 -> SRL, 0100000 -> SRA; for shifts imm_o = zero-extended instr_i[24:20]; other shift funct7 values are illegal; use_imm_o=1.
REQ-016 BRANCH (opcode 1100011, only with ALU_DEC_BRANCH_EN): funct3 000 EQ 11000, 001 NE 11001, 100 LTS 11100, 101 GES 11101, 110 LTU 11110, 111 GEU 11111; 010/011 illegal; imm_o = sign-extended B-immediate {instr_i[31],instr_i[7],instr_i[30:25],instr_i[11:8],0}; use_imm_o=0.
REQ-017 Illegal (any other opcode, instr_i[1:0]!=11, or rejected encoding): alu_op_o=00000, imm_o=0, use_imm_o=0, illegal_o=1; illegal_o=0 for all legal decodes.
REQ-018 Stall: while out_valid_o && !out_ready_i, all outputs stay stable and instr_i is not sampled.
REQ-019 Simultaneous take and accept: out_ready_i=1 and new accept in the same cycle -> out_valid_o stays 1 and the register is replaced by the new decode, with no bubble.
REQ-020 Drain: out_ready_i=1 with no accept -> out_valid_o=0 next cycle; data outputs hold their last value.
REQ-021 illegal_cnt_o increments by 1 on each accepted illegal instruction and saturates at 8'hFF.

Reset
REQ-022 rst_ni=0 clears immediately: out_valid_o=0, alu_op_o=0, imm_o=0, use_imm_o=0, illegal_o=0, illegal_cnt_o=0.
REQ-023 An instruction held in the output register when reset asserts is discarded.
REQ-024 No instruction is accepted during the cycle in which rst_ni is low.

Configuration
REQ-025 Macro ALU_DEC_BRANCH_EN: when defined, BRANCH decode per REQ-016 is included; when undefined, opcode 1100011 is illegal per REQ-017 and increments illegal_cnt_o.

Verification
REQ-026 0x40B50533 (sub) -> next cycle: out_valid_o=1, alu_op_o=10000, use_imm_o=0, illegal_o=0.
REQ-027 0xFFF00093 (addi -1) -> alu_op_o=00000, imm_o=0xFFFFFFFF, use_imm_o=1; 0x4032D293 (srai 3) -> alu_op_o=01101, imm_o=0x00000003.
REQ-028 0x00208463 (beq +8) -> with ALU_DEC_BRANCH_EN: alu_op_o=11000, imm_o=0x00000008, use_imm_o=0, illegal_o=0; without the macro: illegal_o=1, illegal_cnt_o=1.
REQ-029 Hold out_ready_i=0 for 3 cycles with instr_valid_i=1 -> instr_ready_o=0 and outputs stable; raise out_ready_i -> one transfer per cycle, no loss or duplication.
REQ-030 Stream 300 copies of 0x00000000 -> illegal_o=1 and alu_op_o=00000 for each; illegal_cnt_o=0xFF at the end.
REQ-031 Pull rst_ni low while out_valid_o=1 -> out_valid_o=0 and illegal_cnt_o=0 without waiting for a clock edge.
